// File: rtl/arm_mem_pkg.sv
// Shared definitions for the unified-memory arbiter of the multicycle ARM core.
// It holds the arbiter state encoding, the requester ids and the default
// memory latency.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational winner select.
// Ports:
//   req   [1:0] requests, bit 0 = CPU and bit 1 = DMA
//   last        id of the requester served most recently
//   grant       id of the winning requester; only meaningful when |req
// RR_EN = 1 gives a tie to the requester that was not served last.
// RR_EN = 0 gives every tie to the CPU.
module rr_arb2
    import arm_mem_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = REQ_CPU;
        if (req == 2'b11) begin
            grant = (RR_EN != 0) ? ~last : REQ_CPU;
        end else if (req[1]) begin
            grant = REQ_DMA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter that shares the single unified instruction/data memory between the
// CPU (requester 0) and the DMA/debug loader (requester 1). It serialises the
// accesses and owns the fixed-latency memory timing through a wait-state counter.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request, held until cpu_done
//   cpu_rdata, cpu_done, cpu_stall  CPU read data, completion pulse, stall
//   dma_req/we/addr/wdata           DMA request, held until dma_done
//   dma_rdata, dma_done             DMA read data, completion pulse
//   mem_en/we/addr/wdata            memory-side strobes (word-aligned address)
//   mem_rdata                       memory read data, valid on last access cycle
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W     = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_q;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant;
    logic              any_req;
    logic              cnt_zero;

    assign any_req  = cpu_req | dma_req;
    assign cnt_zero = (cnt_q == '0);

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_rr_arb2 (
        .req   ({dma_req, cpu_req}),
        .last  (last_q),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= REQ_DMA;   // makes the CPU win the first tie
            win_q     <= REQ_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q   <= grant;
                        we_q    <= (grant == REQ_DMA) ? dma_we    : cpu_we;
                        addr_q  <= (grant == REQ_DMA) ? dma_addr  : cpu_addr;
                        wdata_q <= (grant == REQ_DMA) ? dma_wdata : cpu_wdata;
                        cnt_q   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        if (!we_q) begin
                            if (win_q == REQ_DMA) dma_rdata <= mem_rdata;
                            else                  cpu_rdata <= mem_rdata;
                        end
                        last_q <= win_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_done  = 1'b0;
        dma_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = BUSY;
            end
            BUSY: begin
                // Drive from latched copies so requester changes cannot
                // disturb an access in flight; the write strobes only once.
                mem_en    = 1'b1;
                mem_we    = we_q & cnt_zero;
                mem_addr  = addr_q & ADDR_MASK;
                mem_wdata = wdata_q;
                if (cnt_zero) state_d = DONE;
            end
            DONE: begin
                cpu_done = (win_q == REQ_CPU);
                dma_done = (win_q == REQ_DMA);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle ARM core between two requesters: the CPU (requester 0) and a DMA/debug loader port (requester 1).
- Serialises accesses and owns the memory-side timing.
- Fixed-latency memory with a wait-state counter.
- CPU stalls (multicycle FSM holds its state) while its access is pending.

Parameters:
- MEM_LAT, 2, memory access cycles per transfer (>=1)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR_EN, 1, 1 = round-robin between requesters; 0 = CPU fixed priority

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_done
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid when cpu_done
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_done
- dma_req  in  1  DMA access request, held until dma_done
- dma_we  in  1  DMA write (1) / read (0)
- dma_addr  in  ADDR_W  DMA byte address
- dma_wdata  in  DATA_W  DMA write data
- dma_rdata  out  DATA_W  DMA read data, valid when dma_done
- dma_done  out  1  one-cycle completion pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on last access cycle

Behaviour:
- Reset values:
  - state = IDLE; cnt = 0; last = 1 (CPU wins first tie).
  - All outputs 0: cpu_done, dma_done, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, dma_rdata.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request:
    - Select a winner:
      - RR_EN = 1: on a tie, grant the requester not served last.
      - RR_EN = 0: CPU always wins a tie.
    - Latch winner id, we, addr and wdata into registers.
    - cnt <= MEM_LAT-1; go to BUSY.
- BUSY:
  - mem_en = 1; mem_addr and mem_wdata are driven from the latched registers.
  - Memory-side outputs are stable for the whole access; input changes are ignored.
  - mem_we = latched_we & (cnt == 0), so a write strobes exactly once.
  - cnt != 0: decrement cnt.
  - cnt == 0:
    - If latched_we = 0, capture mem_rdata into the winner's rdata register.
    - last <= winner; go to DONE.
- DONE:
  - Assert the winner's done for exactly one cycle; mem_en = 0.
  - Unconditionally return to IDLE.
- Latency, idle arbiter to done pulse: MEM_LAT+1 cycles (request seen in cycle 0, done in cycle MEM_LAT+1).
- Throughput: one transfer per MEM_LAT+2 cycles.
- rdata registers hold their value until the next read for that requester. The non-winner's rdata is unchanged.
- Requester protocol:
  - Keep req, we, addr and wdata stable from req rise until done.
  - req high in the cycle after done is treated as a new request.
- A request that drops before it is granted is never served. A request that drops after grant still completes; done pulses regardless.
- Simultaneous requests in IDLE: exactly one is granted; the loser stays pending and is served next.
- Under RR_EN = 1, two continuously requesting masters alternate strictly.
- cpu_stall is combinational. It is high while cpu_req = 1 and low in the cpu_done cycle.
- Reset mid-access: on the next edge, return to IDLE with outputs zeroed. A write that has not reached cnt == 0 is never strobed.
- MEM_LAT = 1: BUSY lasts one cycle, with mem_we strobed in that cycle.
- cnt width: $clog2(MEM_LAT)+1.

Decomposition:
- Shared package arm_mem_pkg:
  - state encoding localparams IDLE/BUSY/DONE
  - requester ids REQ_CPU = 0, REQ_DMA = 1
  - default MEM_LAT
- One sub-module, rr_arb2:
  - Combinational two-way winner select from req[1:0], last and RR_EN.
  - The last-pointer register stays in mem_arbiter.

Test Plan:
- Reset then cpu_req read at addr 0x104, MEM_LAT=2, mem_rdata=0xE3A01005 -> mem_en high for 2 cycles with mem_addr=0x104; cpu_done pulse 3 cycles after request with cpu_rdata=0xE3A01005; cpu_stall high for exactly 3 cycles.
- DMA write addr 0x20, wdata 0xDEADBEEF -> mem_we high for exactly 1 cycle (2nd BUSY cycle) with mem_addr=0x20 and mem_wdata=0xDEADBEEF; dma_done pulse; cpu_rdata unchanged.
- cpu_req and dma_req rise together after reset, RR_EN=1 -> CPU granted first, DMA done 4 cycles after CPU done; both held high continuously -> grants alternate CPU, DMA, CPU, DMA.
- RR_EN=0, both requesting continuously -> CPU granted every transfer; dma_done never pulses while cpu_req stays high.
- Misaligned cpu_addr 0x107 -> mem_addr=0x104.
- Reset asserted during BUSY of a write with cnt=1 -> mem_we never strobes; next cycle all outputs are 0 and state is IDLE; a new request then completes normally.
